// File: rtl/regfile_wb_pkg.sv
// Shared widths, bus types and active levels for the write-back register file.
package regfile_wb_pkg;

  localparam int DATA_BUS_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef logic [DATA_BUS_W-1:0] data_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

  localparam data_bus_t     ZERO_DATA      = '0;
  localparam reg_addr_bus_t ZERO_DATA_ADDR = '0;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_wb_rport.sv
// One combinational read port: reset/enable/r0 gating, then same-cycle write-back forwarding.
// Zero latency; no backpressure (pure mux).
module regfile_rport
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (rst == RST_ENABLE || re != READ_ENABLE || raddr == '0) begin
      rdata = '0;
    end else if (wb_we == WRITE_ENABLE && raddr == wb_waddr) begin
      // new value is returned before it lands in storage
      rdata = wb_wdata;
    end else begin
      rdata = reg_data;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// General-purpose register file fed by write-back, two forwarding read ports and a raw debug port.
// Write-to-storage 1 cycle, forwarded read 0 cycles; no stall input, writes always accepted.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NREG   = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;

  assign commit = (wb_we == WRITE_ENABLE) && (wb_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[wb_waddr] <= wb_wdata;
      if (wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport1 (
    .rst      (rst),
    .re       (re1),
    .raddr    (raddr1),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .reg_data (regs[raddr1]),
    .rdata    (rdata1)
  );

  regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport2 (
    .rst      (rst),
    .re       (re2),
    .raddr    (raddr2),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .reg_data (regs[raddr2]),
    .rdata    (rdata2)
  );

  // debug view is architectural state only, never the in-flight write
  always_comb begin
    dbg_data = '0;
    if (rst != RST_ENABLE && dbg_addr != '0) begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule
